// File: rtl/dcache_pkg.sv
// Shared types and helpers for the dcache data-array controller.
package dcache_pkg;

    localparam int unsigned DCACHE_DATA_W = 32;
    localparam int unsigned DCACHE_BE_W   = DCACHE_DATA_W / 8;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StRdWait = 2'd1,
        StRmwWr  = 2'd2,
        StResp   = 2'd3
    } ctrl_state_e;

    typedef struct packed {
        logic                     we;
        logic                     err;
        logic [DCACHE_DATA_W-1:0] rdata;
    } dcache_rsp_t;

    // Bytes with be set come from new_word, the rest keep old_word.
    function automatic logic [DCACHE_DATA_W-1:0] be_merge(
        input logic [DCACHE_DATA_W-1:0] old_word,
        input logic [DCACHE_DATA_W-1:0] new_word,
        input logic [DCACHE_BE_W-1:0]   be
    );
        logic [DCACHE_DATA_W-1:0] merged;
        merged = old_word;
        for (int i = 0; i < int'(DCACHE_BE_W); i++) begin
            if (be[i]) begin
                merged[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/dcache_mem_ctrl.sv
// Initiator for the dcache data-array port: one request in flight, 1-cycle read latency.
// Define DCACHE_MEM_CTRL_RMW_EN to turn partial-byte-enable writes into read-modify-write.
module dcache_mem_ctrl
    import dcache_pkg::*;
#(
    parameter int unsigned MEM_DEPTH = 256,
    parameter int unsigned DATA_W    = DCACHE_DATA_W,
    localparam int unsigned BE_W     = DATA_W / 8,
    localparam int unsigned ADDR_W   = $clog2(MEM_DEPTH) + 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [DATA_W-1:0] req_wdata_i,
    input  logic [BE_W-1:0]   req_be_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic              rsp_we_o,
    output logic              rsp_err_o,
    output logic [DATA_W-1:0] rsp_rdata_o,
    output logic              mem_ceb_o,
    output logic              mem_ren_o,
    output logic              mem_wen_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    ctrl_state_e       state;
    dcache_rsp_t       rsp;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;

    logic in_range;
    logic accept;
    logic access;
    logic is_rmw;
    logic is_nop;

    assign in_range    = req_addr_i < ADDR_W'(MEM_DEPTH);
    assign req_ready_o = (state == StIdle) && !rst_i;
    assign accept      = req_valid_i && req_ready_o;

`ifdef DCACHE_MEM_CTRL_RMW_EN
    logic [BE_W-1:0] be_q;
    assign is_rmw = req_we_i && (req_be_i != '0) && (req_be_i != '1);
    assign is_nop = req_we_i && (req_be_i == '0);
`else
    logic unused_be;
    assign unused_be = ^req_be_i;
    assign is_rmw    = 1'b0;
    assign is_nop    = 1'b0;
`endif

    // Out-of-range and empty-mask writes are answered without touching the array.
    assign access = accept && in_range && !is_nop;

    always_comb begin
        mem_ceb_o   = 1'b0;
        mem_ren_o   = 1'b0;
        mem_wen_o   = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        if (!rst_i) begin
            if (access) begin
                mem_ceb_o   = 1'b1;
                mem_ren_o   = !req_we_i || is_rmw;
                mem_wen_o   = req_we_i && !is_rmw;
                mem_addr_o  = req_addr_i;
                mem_wdata_o = req_wdata_i;
            end else if (state == StRmwWr) begin
                mem_ceb_o   = 1'b1;
                mem_wen_o   = 1'b1;
                mem_addr_o  = addr_q;
                mem_wdata_o = wdata_q;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state   <= StIdle;
            rsp     <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
`ifdef DCACHE_MEM_CTRL_RMW_EN
            be_q    <= '0;
`endif
        end else begin
            case (state)
                StIdle: begin
                    if (accept) begin
                        rsp     <= '{we: req_we_i, err: !in_range, rdata: '0};
                        addr_q  <= req_addr_i;
                        wdata_q <= req_wdata_i;
`ifdef DCACHE_MEM_CTRL_RMW_EN
                        be_q    <= req_be_i;
`endif
                        if (access && (!req_we_i || is_rmw)) begin
                            state <= StRdWait;
                        end else begin
                            state <= StResp;
                        end
                    end
                end
                StRdWait: begin
`ifdef DCACHE_MEM_CTRL_RMW_EN
                    // Only RMW writes pass through here with we set.
                    if (rsp.we) begin
                        wdata_q <= be_merge(mem_rdata_i, wdata_q, be_q);
                        state   <= StRmwWr;
                    end else
`endif
                    begin
                        rsp.rdata <= mem_rdata_i;
                        state     <= StResp;
                    end
                end
                StRmwWr: begin
                    state <= StResp;
                end
                StResp: begin
                    if (rsp_ready_i) begin
                        state <= StIdle;
                    end
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

    assign rsp_valid_o = (state == StResp);
    assign rsp_we_o    = rsp.we;
    assign rsp_err_o   = rsp.err;
    assign rsp_rdata_o = rsp.rdata;

endmodule
